// File: rtl/ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : ram_arbiter_pkg
//  Description : Shared types and helpers for the RAM arbiter. The optional
//                round-robin build is selected with RAM_ARB_RR_EN.
//  Revision    : 1.0
// ============================================================================
package ram_arbiter_pkg;

    localparam int c_DATA_W = 32;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        IF_RESP = 3'd1,
        LD_RESP = 3'd2,
        RMW_RD  = 3'd3,
        RMW_WR  = 3'd4,
        LS_ACK  = 3'd5
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    // Size 2'b11 is illegal and is reported as an error.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        logic r;
        case (size)
            2'b00:   r = 1'b0;
            2'b01:   r = lsb[0];
            2'b10:   r = (lsb != 2'b00);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_arbiter_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arbiter_lane_align
//  Description : Byte/half lane extraction with sign/zero extension for loads
//                and lane merge for read-modify-write stores.
//  Revision    : 1.0
// ============================================================================
module ram_arbiter_lane_align
    import ram_arbiter_pkg::*;
(
    input  logic [1:0]          lsb,
    input  size_t               size,
    input  logic                zext,
    input  logic [c_DATA_W-1:0] rdata,
    input  logic [c_DATA_W-1:0] wdata,
    output logic [c_DATA_W-1:0] ld_data,
    output logic [c_DATA_W-1:0] st_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte  = rdata[{lsb, 3'b000} +: 8];
        w_half  = lsb[1] ? rdata[31:16] : rdata[15:0];
        ld_data = rdata;
        st_data = wdata;
        case (size)
            SZ_B: begin
                ld_data = {{24{w_byte[7] & ~zext}}, w_byte};
                st_data = rdata;
                st_data[{lsb, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_H: begin
                ld_data = {{16{w_half[15] & ~zext}}, w_half};
                st_data = rdata;
                st_data[{lsb[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arbiter
//  Description : Shares one synchronous RAM between instruction fetch and the
//                load/store unit; sub-word stores use read-modify-write.
//                Define RAM_ARB_RR_EN for round-robin tie breaking.
//  Revision    : 1.0
// ============================================================================
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int RAM_AW     = 5,
    parameter bit RESET_PRIO = 1'b0
) (
    input  logic        clock,
    input  logic        nReset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [1:0]  ls_size,
    input  logic        ls_unsigned,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_done,
    output logic        ls_err,
    output logic [31:0] ls_rdata,
    output logic        ram_r,
    output logic        ram_w,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_dataW,
    input  logic [31:0] ram_dataR
);

    state_t              r_state;
    state_t              w_next;
    logic                r_out_en;
    logic [RAM_AW+1:0]   r_addr;
    size_t               r_size;
    logic                r_zext;
    logic [31:0]         r_wdata;
    logic                r_err;
    logic [31:0]         r_merged;
    logic                w_en;
    logic                w_pick_ls;
    logic                w_pick_if;
    logic                w_ls_misal;
    logic [31:0]         w_ld_data;
    logic [31:0]         w_st_data;
    logic                w_unused;

    function automatic logic [31:0] word_idx(input logic [RAM_AW+1:0] a);
        return 32'(a[RAM_AW+1:2]);
    endfunction

    // Outputs stay quiet during reset and for one cycle after release.
    assign w_en       = nReset & r_out_en;
    assign w_ls_misal = is_misaligned(ls_size, ls_addr[1:0]);

`ifdef RAM_ARB_RR_EN
    owner_t r_rr_last;
    assign w_pick_ls = ls_req & (~if_req | (r_rr_last == OWN_IF));
    assign w_unused  = ^{if_addr[1:0], if_addr[31:RAM_AW+2], ls_addr[31:RAM_AW+2]};
`else
    assign w_pick_ls = ls_req;
    assign w_unused  = ^{if_addr[1:0], if_addr[31:RAM_AW+2], ls_addr[31:RAM_AW+2], RESET_PRIO};
`endif
    assign w_pick_if = if_req & ~w_pick_ls;

    ram_arbiter_lane_align u_lane_align (
        .lsb     (r_addr[1:0]),
        .size    (r_size),
        .zext    (r_zext),
        .rdata   (ram_dataR),
        .wdata   (r_wdata),
        .ld_data (w_ld_data),
        .st_data (w_st_data)
    );

    always_comb begin
        w_next    = r_state;
        if_gnt    = 1'b0;
        if_rvalid = 1'b0;
        if_rdata  = '0;
        ls_gnt    = 1'b0;
        ls_done   = 1'b0;
        ls_err    = 1'b0;
        ls_rdata  = '0;
        ram_r     = 1'b0;
        ram_w     = 1'b0;
        ram_addr  = '0;
        ram_dataW = '0;
        if (!w_en) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_ls) begin
                        ls_gnt = 1'b1;
                        if (w_ls_misal) begin
                            w_next = LS_ACK;
                        end else if (!ls_we) begin
                            ram_r    = 1'b1;
                            ram_addr = word_idx(ls_addr[RAM_AW+1:0]);
                            w_next   = LD_RESP;
                        end else if (ls_size == SZ_W) begin
                            ram_w     = 1'b1;
                            ram_addr  = word_idx(ls_addr[RAM_AW+1:0]);
                            ram_dataW = ls_wdata;
                            w_next    = LS_ACK;
                        end else begin
                            ram_r    = 1'b1;
                            ram_addr = word_idx(ls_addr[RAM_AW+1:0]);
                            w_next   = RMW_RD;
                        end
                    end else if (w_pick_if) begin
                        if_gnt   = 1'b1;
                        ram_r    = 1'b1;
                        ram_addr = word_idx(if_addr[RAM_AW+1:0]);
                        w_next   = IF_RESP;
                    end
                end
                IF_RESP: begin
                    if_rvalid = 1'b1;
                    if_rdata  = ram_dataR;
                    w_next    = IDLE;
                end
                LD_RESP: begin
                    ls_done  = 1'b1;
                    ls_rdata = w_ld_data;
                    w_next   = IDLE;
                end
                RMW_RD: begin
                    w_next = RMW_WR;
                end
                RMW_WR: begin
                    ram_w     = 1'b1;
                    ram_addr  = word_idx(r_addr);
                    ram_dataW = r_merged;
                    w_next    = LS_ACK;
                end
                LS_ACK: begin
                    ls_done = 1'b1;
                    ls_err  = r_err;
                    w_next  = IDLE;
                end
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!nReset) begin
            r_state  <= IDLE;
            r_out_en <= 1'b0;
            r_addr   <= '0;
            r_size   <= SZ_B;
            r_zext   <= 1'b0;
            r_wdata  <= '0;
            r_err    <= 1'b0;
            r_merged <= '0;
        end else begin
            r_state  <= w_next;
            r_out_en <= 1'b1;
            if (ls_gnt) begin
                r_addr  <= ls_addr[RAM_AW+1:0];
                r_size  <= size_t'(ls_size);
                r_zext  <= ls_unsigned;
                r_wdata <= ls_wdata;
                r_err   <= w_ls_misal;
            end
            if (r_state == RMW_RD) begin
                r_merged <= w_st_data;
            end
        end
    end

`ifdef RAM_ARB_RR_EN
    // RESET_PRIO=0 means IF wins the first tie, so LS is recorded as last served.
    always_ff @(posedge clock) begin
        if (!nReset) begin
            r_rr_last <= RESET_PRIO ? OWN_IF : OWN_LS;
        end else if (ls_gnt) begin
            r_rr_last <= OWN_LS;
        end else if (if_gnt) begin
            r_rr_last <= OWN_IF;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_arbiter
//  Description : Scoreboard bench for ram_arbiter with a behavioural RAM.
//  Revision    : 1.0
// ============================================================================
module tb_ram_arbiter;

    logic        clock;
    logic        nReset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [1:0]  ls_size;
    logic        ls_unsigned;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_done;
    logic        ls_err;
    logic [31:0] ls_rdata;
    logic        ram_r;
    logic        ram_w;
    logic [31:0] ram_addr;
    logic [31:0] ram_dataW;
    logic [31:0] ram_dataR;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
        logic [3:0]  lat;
    } ls_exp_t;

    logic [31:0] mem [32];
    logic        q_gnt [$];
    logic [31:0] q_if  [$];
    ls_exp_t     q_ls  [$];
    logic [63:0] q_wr  [$];
    int          n_chk;
    int          n_pass;
    int          cyc;
    int          if_gnt_cyc;
    int          ls_gnt_cyc;

    ram_arbiter #(.RAM_AW(5), .RESET_PRIO(1'b0)) dut (
        .clock       (clock),
        .nReset      (nReset),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_gnt      (if_gnt),
        .if_rvalid   (if_rvalid),
        .if_rdata    (if_rdata),
        .ls_req      (ls_req),
        .ls_we       (ls_we),
        .ls_size     (ls_size),
        .ls_unsigned (ls_unsigned),
        .ls_addr     (ls_addr),
        .ls_wdata    (ls_wdata),
        .ls_gnt      (ls_gnt),
        .ls_done     (ls_done),
        .ls_err      (ls_err),
        .ls_rdata    (ls_rdata),
        .ram_r       (ram_r),
        .ram_w       (ram_w),
        .ram_addr    (ram_addr),
        .ram_dataW   (ram_dataW),
        .ram_dataR   (ram_dataR)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic chk_unexpected(input string name, input logic [63:0] act);
        n_chk++;
        $display("FAIL %s: got unexpected event %h, expected none", name, act);
    endtask

    task automatic wait_gnt(input bit is_ls);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            seen = is_ls ? ls_gnt : if_gnt;
        end
        if (!seen) chk_unexpected(is_ls ? "ls_gnt_timeout" : "if_gnt_timeout", 64'd0);
        @(posedge clock);
        #1;
        if (is_ls) ls_req = 1'b0;
        else       if_req = 1'b0;
    endtask

    task automatic if_access(input logic [31:0] addr, input logic [31:0] exp);
        q_gnt.push_back(1'b0);
        q_if.push_back(exp);
        if_addr = addr;
        if_req  = 1'b1;
        wait_gnt(1'b0);
    endtask

    task automatic ls_access(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic exp_err, input logic [31:0] exp_data,
                             input logic [3:0] lat, input bit expect_resp);
        q_gnt.push_back(1'b1);
        if (expect_resp) q_ls.push_back('{err: exp_err, data: exp_data, lat: lat});
        ls_we       = we;
        ls_size     = size;
        ls_unsigned = uns;
        ls_addr     = addr;
        ls_wdata    = wdata;
        ls_req      = 1'b1;
        wait_gnt(1'b1);
    endtask

    function automatic logic any_out();
        return |{if_gnt, if_rvalid, if_rdata, ls_gnt, ls_done, ls_err, ls_rdata,
                 ram_r, ram_w, ram_addr, ram_dataW};
    endfunction

    initial begin
        n_chk = 0; n_pass = 0; cyc = 0; if_gnt_cyc = 0; ls_gnt_cyc = 0;
        nReset = 1'b0; if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0;
        ls_size = 2'b00; ls_unsigned = 1'b0; ls_addr = '0; ls_wdata = '0;
        ram_dataR = '0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mem[1] = 32'h8080FF7F;
        mem[2] = 32'h11223344;
        mem[3] = 32'hCAFEF00D;
        mem[4] = 32'h55667788;
        mem[5] = 32'h0000000F;

        fork
            forever begin
                @(posedge clock);
                cyc <= cyc + 1;
                if (ram_w) mem[ram_addr[4:0]] <= ram_dataW;
                if (ram_r) ram_dataR <= mem[ram_addr[4:0]];
            end
            forever begin
                @(negedge clock);
                if (if_gnt && ls_gnt) chk("dual_gnt", 64'(if_gnt & ls_gnt), 64'd0);
                if (if_gnt || ls_gnt) begin
                    if (ls_gnt) ls_gnt_cyc = cyc;
                    if (if_gnt) if_gnt_cyc = cyc;
                    if (q_gnt.size() == 0) chk_unexpected("grant", 64'(ls_gnt));
                    else chk("gnt_owner", 64'(ls_gnt), 64'(q_gnt.pop_front()));
                end
                if (if_rvalid) begin
                    if (q_if.size() == 0) chk_unexpected("if_rvalid", 64'(if_rdata));
                    else begin
                        chk("if_rdata", 64'(if_rdata), 64'(q_if.pop_front()));
                        chk("if_latency", 64'(cyc - if_gnt_cyc), 64'd1);
                    end
                end
                if (ls_done) begin
                    if (q_ls.size() == 0) chk_unexpected("ls_done", {31'd0, ls_err, ls_rdata});
                    else begin
                        ls_exp_t e;
                        e = q_ls.pop_front();
                        chk("ls_err_rdata", {31'd0, ls_err, ls_rdata}, {31'd0, e.err, e.data});
                        chk("ls_latency", 64'(cyc - ls_gnt_cyc), 64'(e.lat));
                    end
                end
                if (ram_w) begin
                    chk("ram_rw_excl", 64'(ram_r), 64'd0);
                    if (q_wr.size() == 0) chk_unexpected("ram_w", {ram_addr, ram_dataW});
                    else chk("ram_write", {ram_addr, ram_dataW}, q_wr.pop_front());
                end
            end
        join_none

        // Requests during reset and in the first cycle after must be ignored.
        q_gnt.push_back(1'b0);
        q_if.push_back(32'h0000000F);
        if_addr = 32'h14;
        if_req  = 1'b1;
        repeat (2) begin
            @(negedge clock);
            chk("reset_outs_zero", 64'(any_out()), 64'd0);
        end
        @(posedge clock); #1;
        nReset = 1'b1;
        @(negedge clock);
        chk("post_reset_outs_zero", 64'(any_out()), 64'd0);
        wait_gnt(1'b0);

        ls_access(1'b0, 2'b00, 1'b0, 32'h05, 32'h0, 1'b0, 32'hFFFFFFFF, 4'd1, 1'b1);
        ls_access(1'b0, 2'b00, 1'b1, 32'h06, 32'h0, 1'b0, 32'h00000080, 4'd1, 1'b1);
        ls_access(1'b0, 2'b01, 1'b0, 32'h04, 32'h0, 1'b0, 32'hFFFFFF7F, 4'd1, 1'b1);
        ls_access(1'b0, 2'b01, 1'b1, 32'h06, 32'h0, 1'b0, 32'h00008080, 4'd1, 1'b1);

        q_wr.push_back({32'd2, 32'h1122AA44});
        ls_access(1'b1, 2'b00, 1'b0, 32'h09, 32'hAA, 1'b0, 32'h0, 4'd3, 1'b1);
        q_wr.push_back({32'd2, 32'hBEEFAA44});
        ls_access(1'b1, 2'b01, 1'b0, 32'h0A, 32'hBEEF, 1'b0, 32'h0, 4'd3, 1'b1);
        ls_access(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 1'b0, 32'hBEEFAA44, 4'd1, 1'b1);

        q_wr.push_back({32'd3, 32'h12345678});
        ls_access(1'b1, 2'b10, 1'b0, 32'h0C, 32'h12345678, 1'b0, 32'h0, 4'd1, 1'b1);
        ls_access(1'b1, 2'b10, 1'b0, 32'h0E, 32'hDEADBEEF, 1'b1, 32'h0, 4'd1, 1'b1);
        ls_access(1'b0, 2'b01, 1'b0, 32'h05, 32'h0, 1'b1, 32'h0, 4'd1, 1'b1);
        ls_access(1'b0, 2'b11, 1'b0, 32'h04, 32'h0, 1'b1, 32'h0, 4'd1, 1'b1);
        ls_access(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 1'b0, 32'h12345678, 4'd1, 1'b1);
        if_access(32'h94, 32'h0000000F);

        // Reset while the RMW read is in flight: no write, no completion.
        ls_access(1'b1, 2'b00, 1'b0, 32'h11, 32'h99, 1'b0, 32'h0, 4'd3, 1'b0);
        nReset = 1'b0;
        @(negedge clock);
        chk("abort_outs_zero", 64'(any_out()), 64'd0);
        @(posedge clock); #1;
        nReset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("abort_mem_unchanged", 64'(mem[4]), 64'h55667788);

        // Continuous contention for eight cycles.
`ifdef RAM_ARB_RR_EN
        for (int i = 0; i < 2; i++) begin
            q_gnt.push_back(1'b0);
            q_gnt.push_back(1'b1);
            q_if.push_back(32'h0000000F);
            q_ls.push_back('{err: 1'b0, data: 32'h8080FF7F, lat: 4'd1});
        end
`else
        for (int i = 0; i < 4; i++) begin
            q_gnt.push_back(1'b1);
            q_ls.push_back('{err: 1'b0, data: 32'h8080FF7F, lat: 4'd1});
        end
`endif
        if_addr = 32'h14; if_req = 1'b1;
        ls_we = 1'b0; ls_size = 2'b10; ls_unsigned = 1'b0; ls_addr = 32'h04; ls_req = 1'b1;
        repeat (8) @(posedge clock);
        #1;
        if_req = 1'b0;
        ls_req = 1'b0;
        repeat (4) @(posedge clock);
        #1;

        chk("mem2_final", 64'(mem[2]), 64'hBEEFAA44);
        chk("mem3_final", 64'(mem[3]), 64'h12345678);
        chk("q_gnt_drained", 64'(q_gnt.size()), 64'd0);
        chk("q_if_drained", 64'(q_if.size()), 64'd0);
        chk("q_ls_drained", 64'(q_ls.size()), 64'd0);
        chk("q_wr_drained", 64'(q_wr.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
